mult_share_arbiter: RTL and testbench
=====================================

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of requesters sharing one multiplier (fixed at 4 for this release).
REQ-002 SHALL have parameter DATA_W, default 8, meaning signed operand width; product width is 2*DATA_W.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have Ex_Clock  in  1  system clock; all state is on its rising edge.
REQ-005 SHALL have Ex_Rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have Ch_Enable  in  4  per-channel arbitration enable mask.
REQ-007 SHALL have Req_Valid  in  4  per-channel request valid.
REQ-008 SHALL have Req_Ready  out  4  per-channel accept, one-hot or zero.
REQ-009 SHALL have Req_A  in  32  packed signed operands A; channel i uses bits [8i+7:8i].
REQ-010 SHALL have Req_B  in  32  packed signed operands B; same packing as Req_A.
REQ-011 SHALL have Rsp_Valid  out  4  per-channel one-cycle result strobe.
REQ-012 SHALL have Rsp_Data  out  64  packed signed products; channel i uses bits [16i+15:16i].
REQ-013 SHALL have Busy  out  1  high while any accepted request is still in the pipeline.
REQ-014 SHALL have Grant_Count  out  16  count of accepted requests, wraps modulo 2^16.

Function
REQ-015 SHALL define a channel as eligible when Req_Valid[i] and Ch_Enable[i] are both 1.
REQ-016 SHALL drive Req_Ready combinationally as a one-hot grant to one eligible channel, or all zero when no channel is eligible.
REQ-017 SHALL define acceptance as Req_Valid[i] and Req_Ready[i] both high at a rising edge; at most one acceptance per cycle.
REQ-018 SHALL arbitrate round-robin: search order starts at channel (Last_Grant+1) mod 4; Last_Grant updates only on acceptance.
REQ-019 SHALL, on acceptance at edge t, register A, B and the channel index into stage 1 with a stage-1 valid bit.
REQ-020 SHALL, at edge t+1, compute the full-precision signed 8x8 product of the stage-1 operands (range -16256..16384, no saturation), write it to the Rsp_Data slice of the stage-1 channel, and pulse that Rsp_Valid bit for one cycle; fixed latency of 2 edges.
REQ-021 SHALL hold each Rsp_Data slice until that channel's next result; other channels' slices are unchanged.
REQ-022 SHALL sustain one accepted request per cycle (throughput 1) with no bubbles under continuous eligibility.
REQ-023 SHALL apply Ch_Enable changes to the grant in the same cycle they occur; a request that is already accepted completes regardless of its mask bit.
REQ-024 SHALL ignore Req_A and Req_B of channels that are not granted.
REQ-025 SHALL drive Busy = stage-1 valid OR any Rsp_Valid bit.
REQ-026 SHALL increment Grant_Count by 1 per acceptance, wrapping 0xFFFF->0x0000.

Reset
REQ-027 SHALL, while Ex_Rst_n=0, clear Rsp_Valid=0, Rsp_Data=0, Busy=0, Grant_Count=0, stage-1 valid=0, and Last_Grant=3 so that channel 0 has first priority.
REQ-028 SHALL drive Req_Ready=0 while Ex_Rst_n=0.
REQ-029 SHALL discard in-flight requests when reset is asserted mid-operation; no Rsp_Valid is produced for them after release.
REQ-030 SHALL allow the first acceptance at the first rising edge after Ex_Rst_n deasserts.

Verification
REQ-031 Single request: Ch_Enable=F, only ch2 valid with A=3, B=-4, accepted at edge t -> Rsp_Valid=4'b0100 for one cycle after edge t+1, Rsp_Data[47:32]=16'hFFF4, other slices 0, Grant_Count=1.
REQ-032 Full load: all 4 channels valid continuously from reset -> grant order 0,1,2,3,0,...; one Rsp_Valid per cycle, two cycles behind the matching grant.
REQ-033 Corner products: A=-128, B=-128 -> 16'h4000; A=-128, B=127 -> 16'hC080; A=127, B=127 -> 16'h3F01.
REQ-034 Mask: Ch_Enable=4'b1101 with all channels valid -> grants 0,2,3,0,...; ch1 never receives Req_Ready and its Rsp_Data slice stays 0.
REQ-035 Reset mid-flight: assert Ex_Rst_n=0 one cycle after an acceptance -> no Rsp_Valid, Busy=0, Grant_Count=0, first grant after release goes to ch0.
REQ-036 Wrap: force 65536 acceptances -> Grant_Count returns to 0x0000 with no disturbance to results.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Several requesters share one signed DATA_W x DATA_W multiplier. A
//   round-robin arbiter grants at most one eligible channel per cycle. The
//   accepted operands enter a single register stage. The next edge writes the
//   full-precision product into that channel's result slice and pulses its
//   Rsp_Valid bit. Latency from acceptance to result is two edges, and the
//   throughput is one request per cycle.
//
// Ports
//   Ex_Clock    in   system clock, rising edge
//   Ex_Rst_n    in   asynchronous active-low reset
//   Ch_Enable   in   [NUM_CH]  per-channel arbitration enable mask
//   Req_Valid   in   [NUM_CH]  per-channel request valid
//   Req_Ready   out  [NUM_CH]  one-hot (or zero) combinational grant
//   Req_A/B     in   [NUM_CH*DATA_W]  packed signed operands, channel i at [DATA_W*i +: DATA_W]
//   Rsp_Valid   out  [NUM_CH]  one-cycle result strobe per channel
//   Rsp_Data    out  [NUM_CH*2*DATA_W]  packed products, held until that channel's next result
//   Busy        out  stage-1 valid or any result strobe
//   Grant_Count out  [16]  accepted-request counter, wraps modulo 2^16
module mult_share_arbiter #(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic                       Ex_Clock,
   input  logic                       Ex_Rst_n,
   input  logic [NUM_CH-1:0]          Ch_Enable,
   input  logic [NUM_CH-1:0]          Req_Valid,
   output logic [NUM_CH-1:0]          Req_Ready,
   input  logic [NUM_CH*DATA_W-1:0]   Req_A,
   input  logic [NUM_CH*DATA_W-1:0]   Req_B,
   output logic [NUM_CH-1:0]          Rsp_Valid,
   output logic [NUM_CH*2*DATA_W-1:0] Rsp_Data,
   output logic                       Busy,
   output logic [15:0]                Grant_Count
);

   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int P_W  = 2 * DATA_W;

   logic [NUM_CH-1:0] eligible;
   logic [NUM_CH-1:0] grant;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_found;
   logic              accept;
   logic [DATA_W-1:0] sel_a;
   logic [DATA_W-1:0] sel_b;
   logic [P_W-1:0]    product;

   logic [CH_W-1:0]   last_grant_q, last_grant_d;
   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic [CH_W-1:0]   s1_ch_q, s1_ch_d;
   logic [NUM_CH-1:0] rsp_valid_q, rsp_valid_d;
   logic [15:0]       grant_count_q, grant_count_d;

   assign eligible = Req_Valid & Ch_Enable;

   // Round-robin search starting just after the last accepted channel. The
   // first eligible channel in that rotation wins.
   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_found = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         logic [CH_W-1:0] cand;
         cand = CH_W'((int'(last_grant_q) + 1 + k) % NUM_CH);
         if (!grant_found && eligible[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            grant_found = 1'b1;
         end
      end
   end

   // The grant is masked while reset is held, so nothing looks accepted then.
   assign Req_Ready = Ex_Rst_n ? grant : '0;
   assign accept    = |(Req_Valid & Req_Ready);

   assign sel_a = Req_A[grant_idx*DATA_W +: DATA_W];
   assign sel_b = Req_B[grant_idx*DATA_W +: DATA_W];

   // Both operands are sign-extended to the product width. The low P_W bits
   // of that unsigned product equal the exact signed product, because every
   // DATA_W x DATA_W signed result fits in P_W bits.
   assign product = {{DATA_W{s1_a_q[DATA_W-1]}}, s1_a_q} *
                    {{DATA_W{s1_b_q[DATA_W-1]}}, s1_b_q};

   always_comb begin
      last_grant_d  = last_grant_q;
      s1_valid_d    = accept;
      s1_a_d        = s1_a_q;
      s1_b_d        = s1_b_q;
      s1_ch_d       = s1_ch_q;
      grant_count_d = grant_count_q;
      rsp_valid_d   = '0;
      if (accept) begin
         last_grant_d  = grant_idx;
         s1_a_d        = sel_a;
         s1_b_d        = sel_b;
         s1_ch_d       = grant_idx;
         grant_count_d = grant_count_q + 16'd1;
      end
      if (s1_valid_q) begin
         rsp_valid_d[s1_ch_q] = 1'b1;
      end
   end

   always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
      if (!Ex_Rst_n) begin
         last_grant_q  <= CH_W'(NUM_CH - 1);
         s1_valid_q    <= 1'b0;
         s1_a_q        <= '0;
         s1_b_q        <= '0;
         s1_ch_q       <= '0;
         rsp_valid_q   <= '0;
         grant_count_q <= '0;
      end else begin
         last_grant_q  <= last_grant_d;
         s1_valid_q    <= s1_valid_d;
         s1_a_q        <= s1_a_d;
         s1_b_q        <= s1_b_d;
         s1_ch_q       <= s1_ch_d;
         rsp_valid_q   <= rsp_valid_d;
         grant_count_q <= grant_count_d;
      end
   end

   // Each result slice is written only when its own channel completes, so
   // every other slice keeps its value.
   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rsp
         logic [P_W-1:0] data_q, data_d;

         always_comb begin
            data_d = data_q;
            if (s1_valid_q && (s1_ch_q == CH_W'(gi))) begin
               data_d = product;
            end
         end

         always_ff @(posedge Ex_Clock or negedge Ex_Rst_n) begin
            if (!Ex_Rst_n) begin
               data_q <= '0;
            end else begin
               data_q <= data_d;
            end
         end

         assign Rsp_Data[gi*P_W +: P_W] = data_q;
      end
   endgenerate

   assign Rsp_Valid   = rsp_valid_q;
   assign Busy        = s1_valid_q | (|rsp_valid_q);
   assign Grant_Count = grant_count_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter.
//   The stimulus process drives directed vectors. On every acceptance it
//   pushes the expected result (channel, product, response cycle) into a
//   queue. A monitor on the falling edge pops and compares whenever
//   Rsp_Valid is non-zero. It also flags results that never arrive.
module tb_mult_share_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  en;
   logic [3:0]  valid;
   logic [3:0]  ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [3:0]  rsp_valid;
   logic [63:0] rsp_data;
   logic        busy;
   logic [15:0] gcount;

   mult_share_arbiter #(.NUM_CH(4), .DATA_W(8)) dut (
      .Ex_Clock    (clk),
      .Ex_Rst_n    (rst_n),
      .Ch_Enable   (en),
      .Req_Valid   (valid),
      .Req_Ready   (ready),
      .Req_A       (req_a),
      .Req_B       (req_b),
      .Rsp_Valid   (rsp_valid),
      .Rsp_Data    (rsp_data),
      .Busy        (busy),
      .Grant_Count (gcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          ch;
      logic [15:0] prod;
      int          at_cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_total = 0;
   int          n_pass  = 0;
   logic        verbose = 1'b1;
   logic [1:0]  m_last  = 2'd3;
   logic [15:0] m_count = 16'd0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp_v, cyc);
   endtask

   // Reference round-robin: first eligible channel after the last grant.
   task automatic model_grant(input logic [3:0] elig, output logic [3:0] g, output int gi);
      g  = 4'd0;
      gi = -1;
      for (int k = 0; k < 4; k++) begin
         int idx;
         idx = (int'(m_last) + 1 + k) % 4;
         if (gi < 0 && elig[idx]) begin
            gi    = idx;
            g[idx] = 1'b1;
         end
      end
   endtask

   // Call this just after a falling edge. It applies one vector, checks the
   // grant and the counter, crosses the rising edge, records the expected
   // result, and returns at the next falling edge.
   task automatic step(input logic [3:0] v, input logic [3:0] e,
                       input logic [31:0] av, input logic [31:0] bv, output int granted);
      logic [3:0] g;
      int         gi;
      int         k;
      int         pa;
      int         pb;
      exp_t       it;
      valid = v;
      en    = e;
      req_a = av;
      req_b = bv;
      #1;
      model_grant(v & e, g, gi);
      chk("req_ready", 64'(ready), 64'(g));
      chk("grant_count", 64'(gcount), 64'(m_count));
      k = cyc;
      @(posedge clk);
      if (gi >= 0) begin
         pa        = int'($signed(av[gi*8 +: 8]));
         pb        = int'($signed(bv[gi*8 +: 8]));
         it.ch     = gi;
         it.prod   = 16'(pa * pb);
         it.at_cyc = k + 2;
         exp_q.push_back(it);
         m_last  = 2'(gi);
         m_count = m_count + 16'd1;
      end
      granted = gi;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      int g;
      for (int i = 0; i < n; i++) step(4'h0, 4'hF, 32'h0, 32'h0, g);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      valid = 4'h0;
      en    = 4'h0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      m_last  = 2'd3;
      m_count = 16'd0;
   endtask

   // Monitor: compares every presented result with the head of the queue.
   always @(negedge clk) begin
      if (rst_n) begin
         if (exp_q.size() > 0 && exp_q[0].at_cyc < cyc) begin
            chk("rsp_missing_ch", 64'(rsp_valid), 64'(4'b0001 << exp_q[0].ch));
            void'(exp_q.pop_front());
         end
         if (rsp_valid != 4'h0) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.ch));
               chk("rsp_data", 64'(rsp_data[e.ch*16 +: 16]), 64'(e.prod));
               chk("rsp_latency", 64'(cyc), 64'(e.at_cyc));
               if (verbose)
                  $display("rsp ch%0d data=%h expected=%h cycle=%0d", e.ch, rsp_data[e.ch*16 +: 16], e.prod, cyc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   int          grant_seq[8];
   int          g;
   logic [31:0] av;
   logic [31:0] bv;
   int          exp_fl[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int          exp_mk[8] = '{0, 2, 3, 0, 2, 3, 0, 2};

   initial begin
      rst_n = 1'b0;
      en    = 4'hF;
      valid = 4'hF;
      req_a = 32'h0;
      req_b = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      // Reset state; requests are pending, yet nothing may be granted.
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_data", rsp_data, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_count", 64'(gcount), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single request: ch2, 3 * -4.
      step(4'b0100, 4'hF, 32'hAA03_5555, 32'h77FC_1234, g);
      chk("single_grant", 64'(g), 64'd2);
      chk("single_busy_s1", 64'(busy), 64'd1);
      chk("single_strobe", 64'(rsp_valid), 64'd0);
      idle(1);
      chk("single_busy_rsp", 64'(busy), 64'd1);
      chk("single_strobe_hi", 64'(rsp_valid), 64'b0100);
      idle(1);
      chk("single_strobe_lo", 64'(rsp_valid), 64'd0);
      chk("single_busy_done", 64'(busy), 64'd0);
      chk("single_data", rsp_data, 64'h0000_FFF4_0000_0000);
      chk("single_count", 64'(gcount), 64'd1);

      // Corner products on ch0, ch1 and ch3, one after another.
      step(4'b0001, 4'hF, 32'h0000_0080, 32'h0000_0080, g);
      step(4'b0010, 4'hF, 32'h0000_8000, 32'h0000_7F00, g);
      step(4'b1000, 4'hF, 32'h7F00_0000, 32'h7F00_0000, g);
      idle(2);
      chk("corner_data", rsp_data, 64'h3F01_FFF4_C080_4000);
      chk("corner_count", 64'(gcount), 64'd4);

      // Full load from reset: order 0,1,2,3,...
      do_reset();
      for (int i = 0; i < 8; i++) begin
         av = 32'h0403_0201 + 32'(i) * 32'h0101_0101;
         bv = 32'hFDFE_FF05 - 32'(i) * 32'h0102_0301;
         step(4'hF, 4'hF, av, bv, grant_seq[i]);
      end
      for (int i = 0; i < 8; i++) chk("full_grant", 64'(grant_seq[i]), 64'(exp_fl[i]));
      idle(2);
      chk("full_count", 64'(gcount), 64'd8);

      // Mask 1101 from reset: ch1 is skipped and its slice stays zero.
      do_reset();
      for (int i = 0; i < 8; i++) begin
         av = 32'h9A3C_7E11 ^ 32'(i * 37);
         bv = 32'h15F0_C3A7 + 32'(i * 91);
         step(4'hF, 4'b1101, av, bv, grant_seq[i]);
      end
      for (int i = 0; i < 8; i++) chk("mask_grant", 64'(grant_seq[i]), 64'(exp_mk[i]));
      idle(2);
      chk("mask_ch1_slice", 64'(rsp_data[31:16]), 64'd0);
      // A mask change takes effect in the same cycle.
      step(4'hF, 4'b0100, 32'h0011_2233, 32'h0044_5566, g);
      chk("mask_change", 64'(g), 64'd2);
      idle(2);

      // Reset one cycle after an acceptance: the in-flight result is dropped.
      step(4'hF, 4'hF, 32'h0505_0505, 32'h0303_0303, g);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_count", 64'(gcount), 64'd0);
      chk("midrst_ready", 64'(ready), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      m_last  = 2'd3;
      m_count = 16'd0;
      step(4'hF, 4'hF, 32'h0102_0304, 32'h0506_0708, g);
      chk("midrst_first_grant", 64'(g), 64'd0);

      // Wrap: reach 65536 acceptances in total, with random operands.
      verbose = 1'b0;
      for (int i = 1; i < 65535; i++) begin
         step(4'hF, 4'hF, $urandom, $urandom, g);
      end
      chk("wrap_ffff", 64'(gcount), 64'hFFFF);
      step(4'hF, 4'hF, 32'h8080_7F7F, 32'h7F80_7F80, g);
      chk("wrap_zero", 64'(gcount), 64'd0);
      idle(3);
      verbose = 1'b1;
      chk("wrap_count_after", 64'(gcount), 64'd0);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
